cannon_sequencer: RTL and testbench
===================================

Name: cannon_sequencer

Overview:
- Control FSM for the block-partitioned (Cannon-style) matrix-multiply array: drives read, multiply, accumulate and shift enables over SQRT_P compute steps.
- Sits beside the array datapath and replaces its static enable registers.
- The datapath is purely reactive: it loads on enable_read, settles on enable_mul, accumulates on enable_sum and rotates blocks on enable_shift.

Parameters:
- SQRT_P, 2, processor-grid side; number of multiply-accumulate steps (>=1).
- MUL_LAT, 1, cycles the enable_mul phase lasts per step (>=1).
- STEP_W, 4, width of the step counter and step_idx; must hold SQRT_P-1.
- LAT_W, 4, width of the multiply-phase counter; must hold MUL_LAT-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a full multiply; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- clear_acc  output  1  clear out_sum accumulators (asserted with enable_read).
- enable_read  output  1  load tmp_A/tmp_B blocks from the input matrices.
- enable_mul  output  1  multiply phase; block products settle.
- enable_sum  output  1  accumulate the block product into out_sum.
- enable_shift  output  1  rotate A blocks along rows, B blocks along columns.
- step_idx  output  STEP_W  current compute step, 0..SQRT_P-1.

Behaviour:
- Outputs are registered Moore outputs decoded from state. At most one of enable_read/mul/sum/shift is high in any cycle.
- Reset (async, any time, including mid-operation): state=IDLE; all enables, clear_acc, busy and done = 0; step_idx=0; lat_cnt=0. The first post-reset transition occurs on the first rising clk edge with rst low.
- States and transitions:
  - IDLE: all outputs 0, step_idx=0. If start=1 at an edge, go to LOAD.
  - LOAD (1 cycle): enable_read=1, clear_acc=1. Next state is MUL, with lat_cnt=0.
  - MUL (MUL_LAT cycles): enable_mul=1. lat_cnt increments each cycle. When lat_cnt==MUL_LAT-1, go to SUM.
  - SUM (1 cycle): enable_sum=1. If step_idx==SQRT_P-1, go to DONE. Otherwise go to SHIFT.
  - SHIFT (1 cycle): enable_shift=1. step_idx increments on leaving SHIFT. Next state is MUL, with lat_cnt=0.
  - DONE (1 cycle): done=1, busy=1. Next state is IDLE, where step_idx resets to 0.
- Shift count: exactly SQRT_P-1 shifts per run. No shift after the last SUM.
- Busy length: 1 + SQRT_P*(MUL_LAT+1) + (SQRT_P-1) + 1 cycles.
- step_idx changes only on leaving SHIFT or entering IDLE. It is stable through each MUL/SUM pair.
- start is ignored in every state other than IDLE, including DONE. A start held high continuously re-launches on the edge after DONE→IDLE, giving one IDLE cycle between runs.
- SQRT_P=1: LOAD → MUL → SUM → DONE, no SHIFT state entered.
- Counters wrap only via explicit reloads. Illegal or unused state encodings recover to IDLE.

Optional Feature:
- Macro CANNON_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit), listed after start.
  - abort=1 at an edge in any non-IDLE state forces IDLE next cycle: all enables 0, step_idx=0, and done is NOT pulsed.
  - abort has priority over all other transitions. abort in IDLE has no effect, and start is ignored in any cycle where abort=1.
- When undefined: no abort port; behaviour is as above.

Test Plan:
- Reset mid-run: assert rst asynchronously while in MUL → all outputs 0 immediately, without a clock edge. Release, pulse start → a full run follows.
- SQRT_P=2, MUL_LAT=1, start pulsed 1 cycle → busy for 7 cycles. Enable sequence: read, mul, sum, shift, mul, sum, then done. step_idx is 0,0,0,0,1,1,1, and returns to 0 in IDLE.
- SQRT_P=4, MUL_LAT=3 → busy for 1+16+3+1=21 cycles. Exactly 3 enable_shift pulses and 4 enable_sum pulses; each enable_mul run is 3 cycles long; exactly one done pulse.
- start held high continuously with SQRT_P=2, MUL_LAT=1 → back-to-back runs separated by exactly one IDLE cycle. start pulses during busy or DONE launch nothing extra.
- SQRT_P=1, MUL_LAT=2 → sequence is read, mul, mul, sum, done. enable_shift never asserts.
- With CANNON_SEQ_ABORT_EN: abort during the second SHIFT of a SQRT_P=4 run → IDLE next cycle, done stays 0, step_idx=0. A following start gives a clean full run.

Source files
------------

// File: rtl/cannon_sequencer.sv
// rtl/cannon_sequencer.sv - Cannon-style matrix-multiply control FSM (read/mul/sum/shift enables).
// Optional abort input guarded by CANNON_SEQ_ABORT_EN.
module cannon_sequencer #(
  parameter int SQRT_P  = 2,
  parameter int MUL_LAT = 1,
  parameter int STEP_W  = 4,
  parameter int LAT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef CANNON_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              clear_acc,
  output logic              enable_read,
  output logic              enable_mul,
  output logic              enable_sum,
  output logic              enable_shift,
  output logic [STEP_W-1:0] step_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    SUM   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SQRT_P - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(MUL_LAT - 1);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             launch;

`ifdef CANNON_SEQ_ABORT_EN
  assign launch = start & ~abort;
`else
  assign launch = start;
`endif

  // Outputs are set alongside the state they belong to, so they stay registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      step_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      clear_acc    <= 1'b0;
      enable_read  <= 1'b0;
      enable_mul   <= 1'b0;
      enable_sum   <= 1'b0;
      enable_shift <= 1'b0;
    end else begin
      busy         <= 1'b1;
      done         <= 1'b0;
      clear_acc    <= 1'b0;
      enable_read  <= 1'b0;
      enable_mul   <= 1'b0;
      enable_sum   <= 1'b0;
      enable_shift <= 1'b0;
`ifdef CANNON_SEQ_ABORT_EN
      if (abort && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        step_idx <= '0;
        lat_cnt  <= '0;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            step_idx <= '0;
            lat_cnt  <= '0;
            if (launch) begin
              state       <= LOAD;
              enable_read <= 1'b1;
              clear_acc   <= 1'b1;
            end else begin
              busy <= 1'b0;
            end
          end
          LOAD: begin
            state      <= MUL;
            lat_cnt    <= '0;
            enable_mul <= 1'b1;
          end
          MUL: begin
            if (lat_cnt == LAST_LAT) begin
              state      <= SUM;
              enable_sum <= 1'b1;
            end else begin
              lat_cnt    <= lat_cnt + LAT_W'(1);
              enable_mul <= 1'b1;
            end
          end
          SUM: begin
            if (step_idx == LAST_STEP) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= SHIFT;
              enable_shift <= 1'b1;
            end
          end
          SHIFT: begin
            state      <= MUL;
            step_idx   <= step_idx + STEP_W'(1);
            lat_cnt    <= '0;
            enable_mul <= 1'b1;
          end
          DONE: begin
            state    <= IDLE;
            busy     <= 1'b0;
            step_idx <= '0;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            step_idx <= '0;
            lat_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cannon_sequencer.sv
// tb/tb_cannon_sequencer.sv - self-checking bench for cannon_sequencer over three grid/latency configurations.
module tb_cannon_sequencer;

  localparam int N = 3;
  // {busy, done, clear_acc, read, mul, sum, shift, step_idx[3:0]}
  localparam logic [10:0] IDLE_V = 11'd0;

  int sp_of [N] = '{2, 4, 1};
  int ml_of [N] = '{1, 3, 2};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  start = '0;
  logic [N-1:0]  abort = '0;
  logic [10:0]   obs [N];

  logic [10:0]   cur [N];
  logic [10:0]   q [N][$];

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt [N], done_cnt [N], shift_cnt [N], sum_cnt [N], mul_cnt [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int SPG = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    localparam int MLG = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    logic       busy, done, clear_acc, enable_read, enable_mul, enable_sum, enable_shift;
    logic [3:0] step_idx;
    cannon_sequencer #(.SQRT_P(SPG), .MUL_LAT(MLG), .STEP_W(4), .LAT_W(4)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start[g]),
`ifdef CANNON_SEQ_ABORT_EN
      .abort        (abort[g]),
`endif
      .busy         (busy),
      .done         (done),
      .clear_acc    (clear_acc),
      .enable_read  (enable_read),
      .enable_mul   (enable_mul),
      .enable_sum   (enable_sum),
      .enable_shift (enable_shift),
      .step_idx     (step_idx)
    );
    assign obs[g] = {busy, done, clear_acc, enable_read, enable_mul, enable_sum, enable_shift, step_idx};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(bit b, bit d, bit c, bit r, bit m, bit s, bit h, int step);
    return {b, d, c, r, m, s, h, 4'(step)};
  endfunction

  // A run, written straight from the phase rules: load, then per step MUL_LAT muls, a sum,
  // and a shift between steps only, then done.
  task automatic push_run(input int k);
    q[k].push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    for (int s = 0; s < sp_of[k]; s++) begin
      for (int m = 0; m < ml_of[k]; m++) q[k].push_back(mk(1, 0, 0, 0, 1, 0, 0, s));
      q[k].push_back(mk(1, 0, 0, 0, 0, 1, 0, s));
      if (s < sp_of[k] - 1) q[k].push_back(mk(1, 0, 0, 0, 0, 0, 1, s));
    end
    q[k].push_back(mk(1, 1, 0, 0, 0, 0, 0, sp_of[k] - 1));
  endtask

  task automatic model_step(input int k);
    if (abort[k] && cur[k][10]) begin
      q[k].delete();
      cur[k] = IDLE_V;
    end else begin
      if (!cur[k][10] && start[k] && !abort[k]) push_run(k);
      cur[k] = (q[k].size() > 0) ? q[k].pop_front() : IDLE_V;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      cur[k] = IDLE_V;
    end
  endtask

  task automatic clear_tally();
    for (int k = 0; k < N; k++) begin
      busy_cnt[k] = 0; done_cnt[k] = 0; shift_cnt[k] = 0; sum_cnt[k] = 0; mul_cnt[k] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < N; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("dut%0d_outputs", k), 32'(obs[k]), 32'(cur[k]));
      if (obs[k][10]) busy_cnt[k]++;
      if (obs[k][9])  done_cnt[k]++;
      if (obs[k][6])  mul_cnt[k]++;
      if (obs[k][5])  sum_cnt[k]++;
      if (obs[k][4])  shift_cnt[k]++;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((cur[0][10] || cur[1][10] || cur[2][10]) && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) chk("wait_idle_timeout", 32'(n), 32'(bound - 1));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) chk($sformatf("reset_dut%0d", k), 32'(obs[k]), 32'(IDLE_V));
    rst = 1'b0;
    cycle();

    // Single start pulse on every configuration; check run shape against the closed-form counts.
    clear_tally();
    start = '1;
    cycle();
    start = '0;
    wait_idle(40);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("busy_len_dut%0d", k), 32'(busy_cnt[k]),
          32'(1 + sp_of[k] * (ml_of[k] + 1) + (sp_of[k] - 1) + 1));
      chk($sformatf("shifts_dut%0d", k), 32'(shift_cnt[k]), 32'(sp_of[k] - 1));
      chk($sformatf("sums_dut%0d", k), 32'(sum_cnt[k]), 32'(sp_of[k]));
      chk($sformatf("muls_dut%0d", k), 32'(mul_cnt[k]), 32'(sp_of[k] * ml_of[k]));
      chk($sformatf("dones_dut%0d", k), 32'(done_cnt[k]), 32'd1);
    end

    // start held high: back-to-back runs with exactly one idle cycle in between.
    clear_tally();
    start = '1;
    repeat (40) cycle();
    start = '0;
    wait_idle(40);
    chk("held_start_dones_dut0", 32'(done_cnt[0]), 32'd5);

    // Random start (and abort, when present) traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        start[k] = ($urandom_range(0, 3) == 0);
`ifdef CANNON_SEQ_ABORT_EN
        abort[k] = ($urandom_range(0, 19) == 0);
`endif
      end
      cycle();
    end
    start = '0;
    abort = '0;
    wait_idle(40);

`ifdef CANNON_SEQ_ABORT_EN
    // Abort during the second SHIFT of the SQRT_P=4 run.
    begin
      int n = 0;
      clear_tally();
      start[1] = 1'b1;
      cycle();
      start[1] = 1'b0;
      while (!(cur[1][4] && cur[1][3:0] == 4'd1) && n < 40) begin
        cycle();
        n++;
      end
      chk("abort_reach_shift2", 32'(n < 40), 32'd1);
      abort[1] = 1'b1;
      start[1] = 1'b1;
      cycle();
      abort[1] = 1'b0;
      start[1] = 1'b0;
      chk("abort_idle_dut1", 32'(obs[1]), 32'(IDLE_V));
      cycle();
      chk("abort_no_done", 32'(done_cnt[1]), 32'd0);
      clear_tally();
      start[1] = 1'b1;
      cycle();
      start[1] = 1'b0;
      wait_idle(40);
      chk("abort_rerun_busy", 32'(busy_cnt[1]), 32'd21);
      chk("abort_rerun_done", 32'(done_cnt[1]), 32'd1);
    end
`endif

    // Asynchronous reset while the SQRT_P=4 instance is in its multiply phase.
    begin
      int n = 0;
      start = '1;
      cycle();
      start = '0;
      while (!cur[1][6] && n < 40) begin
        cycle();
        n++;
      end
      chk("rst_reach_mul", 32'(n < 40), 32'd1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < N; k++) chk($sformatf("async_rst_dut%0d", k), 32'(obs[k]), 32'(IDLE_V));
      @(negedge clk);
      rst = 1'b0;
      clear_tally();
      start = '1;
      cycle();
      start = '0;
      wait_idle(40);
      for (int k = 0; k < N; k++)
        chk($sformatf("post_rst_done_dut%0d", k), 32'(done_cnt[k]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
